fifo_drain_ctrl: RTL and testbench

// - Read-side stage directly downstream of the synchronous FIFO.
// - Pops words via the FIFO's rd_en/empty/data_out interface and presents them on a valid/ready stream.
// - Absorbs the FIFO's 1-cycle registered read latency with a 2-entry skid buffer.
// - Sustains 1 word/cycle when the sink is always ready; never under-reads or drops data.

---
 rtl/fifo_drain_ctrl.sv | 118 +++++++++++
 tb/tb_fifo_drain_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_ctrl.sv
// Read-side drain stage: pops a registered-read FIFO into a 2-entry skid buffer and
// presents words on a valid/ready stream. Define WORD_CNT_EN to add the delivered-word counter.
module fifo_drain_ctrl #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  drain_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
`ifdef WORD_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  word_cnt
`endif
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  infl_q;
  logic [DATA_WIDTH-1:0] entry_q [2];
  logic                  head_q, tail_q;
  logic                  pop;
  logic                  capture;
  logic [1:0]            cnt;

  if (DATA_WIDTH < 1 || CNT_WIDTH < 1 || CNT_WIDTH > 32) begin : g_bad_params
    $error("fifo_drain_ctrl: DATA_WIDTH must be >= 1 and CNT_WIDTH in 1..32");
  end

  always_comb begin
    cnt = 2'd0;
    case (state_q)
      StEmpty: cnt = 2'd0;
      StOne:   cnt = 2'd1;
      StTwo:   cnt = 2'd2;
      default: cnt = 2'd0;
    endcase
  end

  // Outputs are forced idle while reset is asserted, even before the first reset edge.
  always_comb begin
    m_valid = rst_n & (state_q != StEmpty);
    m_data  = rst_n ? entry_q[head_q] : '0;
    pop     = m_valid & m_ready;
    capture = infl_q;
  end

  // Credit rule cnt + infl - pop < 2, rearranged so the unsigned sum never underflows.
  always_comb begin
    fifo_rd_en = drain_en & ~fifo_empty & rst_n &
                 (({1'b0, cnt} + {2'b00, infl_q}) < (3'd2 + {2'b00, pop}));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StEmpty: begin
        if (capture) state_d = StOne;
      end
      StOne: begin
        if (capture && !pop)      state_d = StTwo;
        else if (!capture && pop) state_d = StEmpty;
      end
      StTwo: begin
        if (pop && !capture) state_d = StOne;
      end
      default: state_d = StEmpty;
    endcase
  end

  // An in-flight read at reset is deliberately dropped: infl_q clears without capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      infl_q     <= 1'b0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      entry_q[0] <= '0;
      entry_q[1] <= '0;
    end else begin
      state_q <= state_d;
      infl_q  <= fifo_rd_en;
      if (capture) begin
        entry_q[tail_q] <= fifo_data_out;
        tail_q          <= ~tail_q;
      end
      if (pop) begin
        head_q <= ~head_q;
      end
    end
  end

`ifdef WORD_CNT_EN
  logic [CNT_WIDTH-1:0] word_cnt_q;

  // Saturating count of stream transfers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_cnt_q <= '0;
    end else if (pop && (word_cnt_q != {CNT_WIDTH{1'b1}})) begin
      word_cnt_q <= word_cnt_q + 1'b1;
    end
  end

  assign word_cnt = word_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Randomized scoreboard bench for fifo_drain_ctrl with a queue-based FIFO and stream model.
// With WORD_CNT_EN defined the DUT counter is built at width 2 to exercise saturation.
module tb_fifo_drain_ctrl;
  localparam int unsigned DW = 16;
`ifdef WORD_CNT_EN
  localparam int unsigned CW = 2;
`else
  localparam int unsigned CW = 16;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          drain_en;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data_out;
  logic          fifo_rd_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
`ifdef WORD_CNT_EN
  logic [CW-1:0] word_cnt;
`endif

  always #5 clk = ~clk;

  fifo_drain_ctrl #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .drain_en      (drain_en),
    .fifo_empty    (fifo_empty),
    .fifo_data_out (fifo_data_out),
    .fifo_rd_en    (fifo_rd_en),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready)
`ifdef WORD_CNT_EN
    ,
    .word_cnt      (word_cnt)
`endif
  );

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] fq[$];     // words stored in the upstream FIFO
  logic [DW-1:0] exp_q[$];  // words written but not yet delivered, in order
  int            taken = 0; // words read out of the FIFO but not yet delivered
  int            delivered = 0;
  int            mcnt = 0;  // expected word_cnt
  logic          hold = 1'b0;
  logic [DW-1:0] hold_data = '0;
  int            d0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fifo_write(input logic [DW-1:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
    check(name, exp_q.size(), 0);
    repeat (2) step();
  endtask

  // Upstream FIFO: one-cycle registered read. A reset edge discards everything already
  // taken from it but not yet delivered.
  initial begin
    fifo_data_out <= '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        for (int i = 0; i < taken; i++) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        taken = 0;
      end
      if (fifo_rd_en && fq.size() > 0) begin
        fifo_data_out <= fq.pop_front();
        taken++;
        fifo_empty <= (fq.size() == 0);
      end
    end
  end

  // Monitor: protocol rules every cycle, scoreboard compare on every transfer.
  initial begin
    forever begin
      @(negedge clk);
      check("rd_en_while_empty", fifo_rd_en & fifo_empty, 0);
      check("rd_en_while_drain_off", fifo_rd_en & ~drain_en, 0);
      check("over_read", (taken > 2), 0);
      if (!rst_n) begin
        check("rst_m_valid", m_valid, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_m_data", m_data, 0);
        hold = 1'b0;
        mcnt = 0;
      end else begin
        if (hold) begin
          check("hold_valid", m_valid, 1);
          check("hold_data", m_data, hold_data);
        end
`ifdef WORD_CNT_EN
        check("word_cnt", word_cnt, mcnt);
`endif
        if (m_valid && m_ready) begin
          check("word_expected", (exp_q.size() > 0), 1);
          if (exp_q.size() > 0) check("m_data_order", m_data, exp_q.pop_front());
          taken--;
          delivered++;
          if (mcnt < 2 ** CW - 1) mcnt++;
        end
        hold      = m_valid & ~m_ready;
        hold_data = m_data;
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    drain_en   = 1'b1;
    m_ready    = 1'b1;
    fifo_empty = 1'b1;

    // Reset with a non-empty FIFO: no read may issue.
    step();
    for (int k = 0; k < 3; k++) fifo_write(DW'(16'hA001 + k));
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_m_valid", m_valid, 0);
`ifdef WORD_CNT_EN
    check("reset_word_cnt", word_cnt, 0);
`endif
    wait_drain(50, "reset_drain");

    // Streaming: 2-cycle latency then one word per cycle.
    for (int k = 0; k < 8; k++) fifo_write(DW'(k + 1));
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      check("stream_rd_en", fifo_rd_en, (k <= 7));
      check("stream_valid", m_valid, (k >= 2 && k <= 9));
      if (k >= 2 && k <= 9) check("stream_data", m_data, k - 1);
    end
    wait_drain(50, "stream_drain");

    // Backpressure: exactly two reads, head word held.
    m_ready = 1'b0;
    for (int k = 0; k < 3; k++) fifo_write(DW'(k + 1));
    repeat (6) step();
    check("bp_reads", fq.size(), 1);
    check("bp_valid", m_valid, 1);
    check("bp_data", m_data, 1);
    m_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("bp_release_data", m_data, k);
    end
    wait_drain(50, "bp_drain");

    // drain_en dropped the cycle after a read issues: that word still arrives.
    fifo_write(DW'(16'h00D1));
    step();
    drain_en = 1'b0;
    d0 = delivered;
    fifo_write(DW'(16'h00D2));
    fifo_write(DW'(16'h00D3));
    repeat (8) step();
    check("drop_remaining", fq.size(), 2);
    check("drop_delivered", delivered - d0, 1);
    drain_en = 1'b1;
    wait_drain(50, "drop_drain");

    // Reset with one buffered word and one read in flight.
    m_ready = 1'b0;
    d0 = delivered;
    for (int k = 0; k < 3; k++) fifo_write(DW'(16'h00E1 + k));
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_valid", m_valid, 0);
    m_ready = 1'b1;
    wait_drain(50, "midrst_drain");
    check("midrst_delivered", delivered - d0, 1);

    // Randomized traffic with occasional resets.
    repeat (3000) begin
      step();
      drain_en = ($urandom_range(0, 3) != 0);
      m_ready  = ($urandom_range(0, 3) != 0);
      rst_n    = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 2) != 0 && fq.size() < 32) fifo_write(DW'($urandom));
    end
    step();
    rst_n    = 1'b1;
    drain_en = 1'b1;
    m_ready  = 1'b1;
    wait_drain(200, "random_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
